// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits count_i pulses of HIGH_CYCLES high / LOW_CYCLES low, then a done strobe
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   start_i : request a train (accepted when ready_o=1)
//   count_i : number of pulses, latched on acceptance
//   ready_o : high in IDLE only
//   pulse_o : registered pulse-train output
//   done_o  : registered one-cycle completion strobe
module pulse_train_gen #(
  parameter int HIGH_CYCLES = 5,
  parameter int LOW_CYCLES  = 5,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             ready_o,
  output logic             pulse_o,
  output logic             done_o
);
  localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int PW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t           state, state_n;
  logic [PW-1:0]    phase, phase_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic             done_n;
  logic             accept;
  assign ready_o = (state == IDLE);
  assign accept  = start_i & ready_o;
  // phase counts down to zero and is reloaded on each state change; rem is
  // decremented at the end of every HIGH phase so it can never wrap
  always_comb begin
    state_n = state;
    phase_n = phase;
    rem_n   = rem;
    done_n  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        rem_n = count_i;
        if (count_i != '0) begin
          state_n = HIGH;
          phase_n = PW'(HIGH_CYCLES - 1);
        end else done_n = 1'b1;
      end
      HIGH: if (phase == '0) begin
        state_n = LOW;
        phase_n = PW'(LOW_CYCLES - 1);
        rem_n   = rem - 1'b1;
      end else phase_n = phase - 1'b1;
      LOW: if (phase == '0) begin
        if (rem != '0) begin
          state_n = HIGH;
          phase_n = PW'(HIGH_CYCLES - 1);
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end else phase_n = phase - 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // pulse_o follows the next state so it rises in the first cycle after acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      phase   <= '0;
      rem     <= '0;
      pulse_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      rem     <= rem_n;
      pulse_o <= (state_n == HIGH);
      done_o  <= done_n;
    end
  end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: scoreboard bench for pulse_train_gen with HIGH=2, LOW=3, CNT_W=8
module tb_pulse_train_gen;
  logic       clk, rst_n, start, pulse, done, ready;
  logic [7:0] count;
  int         compared = 0, failed = 0, edges = 0;
  string      tag = "init";
  typedef struct { logic [2:0] v; string tag; } exp_t;
  exp_t q[$];
  pulse_train_gen #(.HIGH_CYCLES(2), .LOW_CYCLES(3), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .count_i(count),
    .ready_o(ready), .pulse_o(pulse), .done_o(done)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge pulse) edges++;
  // monitor: one expected {pulse,done,ready} per cycle, sampled on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      compared++;
      if ({pulse, done, ready} !== e.v) begin
        failed++;
        $display("FAIL %s t=%0t: pulse/done/ready got %b required %b", e.tag, $time, {pulse, done, ready}, e.v);
      end
    end
  end
  task automatic push(input logic p, input logic d, input logic r);
    exp_t e;
    e.v = {p, d, r};
    e.tag = tag;
    q.push_back(e);
  endtask
  // expected cycles 1..n*5 after acceptance, then the done/ready cycle
  task automatic push_train(input int n);
    for (int k = 1; k <= n * 5; k++) push(((k - 1) % 5) < 2, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b1);
  endtask
  task automatic wait_drain(input int budget);
    int i = 0;
    while (q.size() > 0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (q.size() > 0) begin
      compared++;
      failed++;
      $display("FAIL %s timeout: %0d expected cycles left, required 0", tag, q.size());
      q.delete();
    end
  endtask
  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: pulse/done/ready got %b required %b", name, got, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    count = '0;
    #12;
    chk("in_reset", {pulse, done, ready}, 3'b001);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tag = "after_reset";
    repeat (2) push(1'b0, 1'b0, 1'b1);
    wait_drain(10);
    tag = "single";
    @(posedge clk);
    #1 push(1'b0, 1'b0, 1'b1);
    start = 1'b1;
    count = 8'd3;
    push_train(3);
    push(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain(40);
    tag = "zero";
    @(posedge clk);
    #1 push(1'b0, 1'b0, 1'b1);
    start = 1'b1;
    count = 8'd0;
    push(1'b0, 1'b1, 1'b1);
    repeat (2) push(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain(10);
    tag = "busy";
    @(posedge clk);
    #1 push(1'b0, 1'b0, 1'b1);
    start = 1'b1;
    count = 8'd2;
    push_train(2);
    push_train(9);
    push(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    count = 8'd9;
    repeat (9) @(posedge clk);
    #1 start = 1'b0;
    count = 8'd77;
    wait_drain(80);
    tag = "back_to_back";
    @(posedge clk);
    #1 push(1'b0, 1'b0, 1'b1);
    start = 1'b1;
    count = 8'd1;
    repeat (3) push_train(1);
    push(1'b0, 1'b0, 1'b1);
    repeat (13) @(posedge clk);
    #1 start = 1'b0;
    wait_drain(30);
    tag = "reset_mid";
    @(posedge clk);
    #1 push(1'b0, 1'b0, 1'b1);
    start = 1'b1;
    count = 8'd5;
    for (int k = 1; k <= 6; k++) push(((k - 1) % 5) < 2, 1'b0, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain(20);
    chk("before_abort", {pulse, done, ready}, 3'b100);
    rst_n = 1'b0;
    #1 chk("abort_async", {pulse, done, ready}, 3'b001);
    @(negedge clk);
    #1 chk("abort_hold", {pulse, done, ready}, 3'b001);
    rst_n = 1'b1;
    repeat (40) push(1'b0, 1'b0, 1'b1);
    wait_drain(60);
    tag = "max_count";
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    start = 1'b1;
    count = 8'd255;
    edges = 0;
    push_train(255);
    push(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    count = '0;
    wait_drain(1400);
    compared++;
    if (edges != 255) begin
      failed++;
      $display("FAIL max_edges: pulse rising edges got %0d required 255", edges);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
